branch_seq_ctrl: RTL and testbench

BRANCH_SEQ_CTRL -- requirements
Module: branch_seq_ctrl

---
 rtl/branch_seq_ctrl.sv | 97 +++++++++
 tb/tb_branch_seq_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl: instruction fetch / branch sequencer with flag register.
// Fetches from imem at pc, then spends one EVAL cycle per instruction: issues
// non-branch words on instr/instr_valid, resolves class 4'hC conditional branches
// against {Z,N,C} (flag_in forwarded when flag_we is set that cycle), and inserts
// one flush bubble after a taken branch.
// Ports: clk, rst (async, active-high), run; imem_req/imem_addr/imem_ack/imem_data;
// flag_we/flag_in; instr_valid/instr, br_taken, flush, pc, znc, link_we/link_data.
// Optional macro BR_LINK_EN: class 4'hD becomes branch-and-link.
module branch_seq_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        flag_we,
  input  logic [2:0]  flag_in,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic        br_taken,
  output logic        flush,
  output logic [15:0] pc,
  output logic [2:0]  znc,
  output logic        link_we,
  output logic [15:0] link_data
);
  typedef enum logic [1:0] {IDLE, FETCH, EVAL, FLUSH} state_t;
  state_t state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d, pc_inc, target;
  logic [2:0] znc_q, flg;
  logic is_br, is_link, cond, taken;
  // a flag write in the EVAL cycle must steer that cycle's branch decision
  assign flg = flag_we ? flag_in : znc_q;
  assign pc_inc = pc_q + 16'd1;
  assign target = pc_inc + {{8{ir_q[7]}}, ir_q[7:0]};
  assign cond = ir_q[11] ? ((|(ir_q[10:8] & ~flg)) || (&ir_q[10:8]))
                         : ((|(ir_q[10:8] & flg)) || (ir_q[10:8] == 3'b000));
`ifdef BR_LINK_EN
  assign is_link = ir_q[15:12] == 4'hD;
  assign link_data = link_we ? pc_inc : 16'h0000;
`else
  assign is_link = 1'b0;
  assign link_data = 16'h0000;
`endif
  assign is_br = (ir_q[15:12] == 4'hC) || is_link;
  assign taken = is_br && cond;
  assign imem_addr = pc_q;
  assign instr = ir_q;
  assign pc = pc_q;
  assign znc = znc_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    imem_req = 1'b0;
    instr_valid = 1'b0;
    br_taken = 1'b0;
    flush = 1'b0;
    link_we = 1'b0;
    case (state_q)
      IDLE: state_d = run ? FETCH : IDLE;
      FETCH: begin
        imem_req = 1'b1;
        ir_d = imem_ack ? imem_data : ir_q;
        state_d = imem_ack ? EVAL : FETCH;
      end
      EVAL: begin
        pc_d = taken ? target : pc_inc;
        br_taken = taken;
        instr_valid = !is_br;
        link_we = is_link && cond;
        state_d = taken ? FLUSH : (run ? FETCH : IDLE);
      end
      FLUSH: begin
        flush = 1'b1;
        state_d = run ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      ir_q <= 16'h0000;
      znc_q <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      if (flag_we) znc_q <= flag_in;
    end
  end
endmodule

// File: tb/tb_branch_seq_ctrl.sv
// tb_branch_seq_ctrl: directed-vector bench for branch_seq_ctrl.
module tb_branch_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, imem_ack = 1'b0, flag_we = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [2:0] flag_in = 3'b000;
  logic imem_req, instr_valid, br_taken, flush, link_we;
  logic [15:0] imem_addr, instr, pc, link_data;
  logic [2:0] znc;
  logic eval_fw = 1'b0;
  logic [2:0] eval_fin = 3'b000;
  int checks = 0, failures = 0;

  branch_seq_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .flag_we(flag_we), .flag_in(flag_in),
    .instr_valid(instr_valid), .instr(instr), .br_taken(br_taken), .flush(flush),
    .pc(pc), .znc(znc), .link_we(link_we), .link_data(link_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic set_flags(input logic [2:0] f);
    flag_we = 1'b1;
    flag_in = f;
    @(negedge clk);
    flag_we = 1'b0;
    chk("znc_wr", {13'd0, znc}, {13'd0, f});
  endtask

  // wait for a fetch at a, ack it with d, check the EVAL cycle and the resulting pc
  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic iv, input logic bt,
                      input logic [15:0] np, input logic lk, input logic [15:0] ld);
    for (int n = 0; n < 20 && !imem_req; n++) @(negedge clk);
    chk("req", {15'd0, imem_req}, 16'd1);
    chk("addr", imem_addr, a);
    imem_ack = 1'b1;
    imem_data = d;
    @(negedge clk);
    imem_ack = 1'b0;
    flag_we = eval_fw;
    flag_in = eval_fin;
    #1;
    chk("instr_valid", {15'd0, instr_valid}, {15'd0, iv});
    chk("br_taken", {15'd0, br_taken}, {15'd0, bt});
    chk("link_we", {15'd0, link_we}, {15'd0, lk});
    chk("link_data", link_data, ld);
    if (iv) chk("instr", instr, d);
    @(negedge clk);
    flag_we = 1'b0;
    eval_fw = 1'b0;
    chk("pc", pc, np);
    chk("flush", {15'd0, flush}, {15'd0, bt});
  endtask

  initial begin
    @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_znc", {13'd0, znc}, 16'd0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pulses", {12'd0, instr_valid, br_taken, flush, link_we}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req", {15'd0, imem_req}, 16'd0);
    run = 1'b1;
    step(16'h0000, 16'h1234, 1, 0, 16'h0001, 0, 16'h0000);
    step(16'h0001, 16'h1234, 1, 0, 16'h0002, 0, 16'h0000);
    step(16'h0002, 16'h1234, 1, 0, 16'h0003, 0, 16'h0000);
    step(16'h0003, 16'hC00C, 0, 1, 16'h0010, 0, 16'h0000);
    set_flags(3'b100);
    step(16'h0010, 16'hC405, 0, 1, 16'h0016, 0, 16'h0000);
    set_flags(3'b000);
    step(16'h0016, 16'hC009, 0, 1, 16'h0020, 0, 16'h0000);
    step(16'h0020, 16'hC4FE, 0, 0, 16'h0021, 0, 16'h0000);
    step(16'h0021, 16'hC0FE, 0, 1, 16'h0020, 0, 16'h0000);
    step(16'h0020, 16'hCCFE, 0, 1, 16'h001F, 0, 16'h0000);
    step(16'h001F, 16'hC0E0, 0, 1, 16'h0000, 0, 16'h0000);
    eval_fw = 1'b1;
    eval_fin = 3'b001;
    step(16'h0000, 16'hC180, 0, 1, 16'hFF81, 0, 16'h0000);
    chk("znc_fwd", {13'd0, znc}, 16'h0001);
    step(16'hFF81, 16'hC07D, 0, 1, 16'hFFFF, 0, 16'h0000);
    step(16'hFFFF, 16'h1234, 1, 0, 16'h0000, 0, 16'h0000);
`ifdef BR_LINK_EN
    step(16'h0000, 16'hC004, 0, 1, 16'h0005, 0, 16'h0000);
    step(16'h0005, 16'hD003, 0, 1, 16'h0009, 1, 16'h0006);
    run = 1'b0;
    step(16'h0009, 16'h1234, 1, 0, 16'h000A, 0, 16'h0000);
`else
    step(16'h0000, 16'hD003, 1, 0, 16'h0001, 0, 16'h0000);
    run = 1'b0;
    step(16'h0001, 16'h1234, 1, 0, 16'h0002, 0, 16'h0000);
`endif
    chk("stop_req0", {15'd0, imem_req}, 16'd0);
    @(negedge clk);
    chk("stop_req1", {15'd0, imem_req}, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_znc", {13'd0, znc}, 16'd0);
    run = 1'b1;
    step(16'h0000, 16'hC041, 0, 1, 16'h0042, 0, 16'h0000);
    for (int n = 0; n < 20 && !imem_req; n++) @(negedge clk);
    chk("mid_addr", imem_addr, 16'h0042);
    #2 rst = 1'b1;
    #1;
    chk("mid_req", {15'd0, imem_req}, 16'd0);
    chk("mid_pc", pc, 16'h0000);
    run = 1'b0;
    imem_ack = 1'b1;
    imem_data = 16'hC405;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("post_req", {15'd0, imem_req}, 16'd0);
    chk("post_instr", instr, 16'h0000);
    chk("post_pulses", {14'd0, instr_valid, br_taken}, 16'd0);
    chk("post_pc", pc, 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
